// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - self-test engine for the 8-bit alu: LFSR vectors, golden model, fail capture.
// ALU_BIST_FLAGS_CHECK_EN: also compare sign (all ops) and ov/cout (ops 000/001).
module alu_bist #(
    parameter int          VECTORS = 16,
    parameter logic [7:0]  SEED    = 8'hA5,
    parameter int          SETTLE  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [2:0] op,
    input  logic [7:0] z,
    input  logic       ov,
    input  logic       sign,
    input  logic       cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_count,
    output logic [2:0] first_fail_op,
    output logic [7:0] first_fail_a,
    output logic [7:0] first_fail_b
);
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [7:0] VEC_LAST  = 8'(VECTORS - 1);
    localparam logic [3:0] SETTLE_LD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_next;
    logic [2:0]  op_idx_q, op_idx_d;
    logic [7:0]  vec_q, vec_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [7:0]  fail_count_q, fail_count_d;
    logic [2:0]  ff_op_q, ff_op_d;
    logic [7:0]  ff_a_q, ff_a_d, ff_b_q, ff_b_d;

    logic [8:0]  sum;
    logic [7:0]  exp_z;
    logic        exp_ov, exp_cout, mismatch;

    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        exp_z    = 8'h00;
        exp_ov   = 1'b0;
        exp_cout = 1'b0;
        case (op_q)
            3'b000: begin
                exp_z    = sum[7:0];
                exp_cout = sum[8];
                exp_ov   = (a_q[7] == b_q[7]) && (sum[7] != a_q[7]);
            end
            3'b001: begin
                exp_z    = a_q + 8'd1;
                exp_cout = (a_q == 8'hFF);
                exp_ov   = (a_q == 8'h7F);
            end
            3'b010:  exp_z = a_q & b_q;
            3'b011:  exp_z = a_q | b_q;
            3'b100:  exp_z = a_q ^ b_q;
            3'b101:  exp_z = ~a_q;
            3'b110:  exp_z = {1'b0, a_q[7:1]};
            default: exp_z = {a_q[6:0], 1'b0};
        endcase
    end

`ifdef ALU_BIST_FLAGS_CHECK_EN
    assign mismatch = (z != exp_z) || (sign != exp_z[7]) ||
                      ((op_q[2:1] == 2'b00) && ((ov != exp_ov) || (cout != exp_cout)));
`else
    logic unused_flags;
    assign unused_flags = ^{ov, sign, cout, exp_ov, exp_cout};
    assign mismatch     = (z != exp_z);
`endif

    // Fibonacci taps 16,14,13,11
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        op_idx_d     = op_idx_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;
        ff_op_d      = ff_op_q;
        ff_a_d       = ff_a_q;
        ff_b_d       = ff_b_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    fail_count_d = 8'h00;
                    ff_op_d      = 3'b000;
                    ff_a_d       = 8'h00;
                    ff_b_d       = 8'h00;
                    lfsr_d       = {SEED, ~SEED};
                    op_idx_d     = 3'b000;
                    vec_d        = 8'h00;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    state_d      = S_DRIVE;
                end
            end
            S_DRIVE: begin
                a_d  = lfsr_q[15:8];
                b_d  = lfsr_q[7:0];
                op_d = op_idx_q;
                if (SETTLE == 0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = SETTLE_LD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) state_d = S_CHECK;
                else                  settle_d = settle_q - 4'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (fail_count_q == 8'h00) begin
                        ff_op_d = op_q;
                        ff_a_d  = a_q;
                        ff_b_d  = b_q;
                    end
                    if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
                end
                lfsr_d = lfsr_next;
                if ((op_idx_q == 3'b111) && (vec_q == VEC_LAST)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == 8'h00);
                    state_d = S_DONE;
                end else begin
                    if (vec_q == VEC_LAST) begin
                        vec_d    = 8'h00;
                        op_idx_d = op_idx_q + 3'd1;
                    end else begin
                        vec_d = vec_q + 8'd1;
                    end
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= 16'h0000;
            op_idx_q     <= 3'b000;
            vec_q        <= 8'h00;
            settle_q     <= 4'd0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            op_q         <= 3'b000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 8'h00;
            ff_op_q      <= 3'b000;
            ff_a_q       <= 8'h00;
            ff_b_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            op_idx_q     <= op_idx_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
            ff_op_q      <= ff_op_d;
            ff_a_q       <= ff_a_d;
            ff_b_q       <= ff_b_d;
        end
    end

    assign a             = a_q;
    assign b             = b_q;
    assign op            = op_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_count    = fail_count_q;
    assign first_fail_op = ff_op_q;
    assign first_fail_a  = ff_a_q;
    assign first_fail_b  = ff_b_q;
endmodule

// File: doc/alu_bist.md
# alu_bist

Hardware self-test engine for the 8-bit combinational `alu`. It drives operands and opcodes into the ALU, samples `z`/`ov`/`sign`/`cout`, and compares them against an internal golden model. It counts mismatches and captures the first failing vector. It sits beside the ALU in place of the bench stimulus, so the same checks run on silicon and FPGA.

## Interface
- `VECTORS`, 16: operand pairs applied per opcode, range 1..255.
- `SEED`, 8'hA5: LFSR seed byte.
- `SETTLE`, 1: wait cycles between driving the ALU and sampling it, range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to run; accepted only in IDLE or DONE.
- `a` out 8: operand A to the ALU, registered.
- `b` out 8: operand B to the ALU, registered.
- `op` out 3: opcode to the ALU, registered.
- `z` in 8: ALU result.
- `ov` in 1: ALU signed overflow.
- `sign` in 1: ALU sign flag.
- `cout` in 1: ALU carry out.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle before `done` rises.
- `done` out 1: high and held once a run completes.
- `pass` out 1: valid while `done`=1; equals (`fail_count`==0).
- `fail_count` out 8: mismatch count, saturates at 255.
- `first_fail_op` out 3: opcode of the first mismatch.
- `first_fail_a` out 8: operand A of the first mismatch.
- `first_fail_b` out 8: operand B of the first mismatch.

## Operation
- Golden model, 8-bit wrap arithmetic:
  - `000`: z=a+b; cout=carry out of bit 7; ov=(a[7]==b[7])&&(z[7]!=a[7]).
  - `001`: z=a+1; cout=(a==8'hFF); ov=(a==8'h7F).
  - `010`: z=a&b.
  - `011`: z=a|b.
  - `100`: z=a^b.
  - `101`: z=~a.
  - `110`: z=a>>1, logical, zero fill.
  - `111`: z=a<<1.
  - All opcodes: sign=z[7].
- Operand source: 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Loaded with {SEED,~SEED} on each accepted `start`.
  - a=lfsr[15:8], b=lfsr[7:0].
  - Advances once per CHECK; runs continuously across opcodes.
- Order: op 000..111 in the outer loop, VECTORS vectors in the inner loop. Total 8*VECTORS checks per run.
- FSM states and transitions:
  - IDLE: `start` → clear counters and first-fail registers, load LFSR, op=0, vec=0 → DRIVE.
  - DRIVE: register a/b/op from LFSR and counters. If SETTLE=0 → CHECK, else load the settle counter → SETTLE.
  - SETTLE: count down to 0 → CHECK.
  - CHECK: compare, then update `fail_count` and the first-fail capture (only when `fail_count` was 0), then advance the LFSR.
    - Last vector of op 111 → DONE.
    - Otherwise increment vec; on wrap, increment op and clear vec. → DRIVE.
  - DONE: `done`=1 and results held. `start` → same actions as in IDLE → DRIVE.
- `start` in DRIVE, SETTLE or CHECK is ignored.
- `rst` at any time, including mid-run: next state IDLE, all outputs return to reset values.
- Reset values: a=b=0, op=0, busy=0, done=0, pass=0, fail_count=0, first_fail_op=0, first_fail_a=0, first_fail_b=0.

## Timing
- Each vector takes 2+SETTLE cycles (DRIVE, SETTLE×SETTLE, CHECK).
- With `start` sampled at edge 0, `done` rises at edge 1+8*VECTORS*(2+SETTLE). With defaults this is edge 385.
- ALU inputs are stable for at least SETTLE+1 cycles before sampling at the CHECK edge.
- `done` falls on the edge that accepts a restart; `busy` rises on the same edge.
- `fail_count` and first-fail outputs update on CHECK edges only.

## Configuration
- `ALU_BIST_FLAGS_CHECK_EN`
  - Defined: a mismatch is any difference in z; in sign for all ops; or in ov or cout for ops 000/001.
  - Undefined: only z is compared; flag inputs are ignored and may be left unconnected.

## Test plan
- Golden `alu`, defaults, `start` pulse at edge 0 → `busy`=1 from edge 1, `done`=1 and `pass`=1 at edge 385, `fail_count`=0.
- Fault: op 110 implemented as arithmetic shift → `pass`=0, `first_fail_op`=3'b110, `first_fail_a`[7]=1, `fail_count` equals the number of op-110 vectors with a[7]=1.
- Fault: `ov` tied 0, macro defined → failures only on op 000/001 vectors with expected ov=1. Same fault, macro undefined → `pass`=1.
- Fault: `z` tied 8'h00, VECTORS=64 → `fail_count`=255 (saturated), `first_fail_op`=3'b000.
- `rst` high for one cycle at edge 100 → all outputs at reset values at edge 101. A following `start` reproduces the clean-run results exactly.
- `start` pulsed at edge 50 (busy) → ignored, `done` still at edge 385. `start` in DONE → `done`=0 next edge, rerun gives identical results.
